// File: rtl/nexys_starship_pkg.sv
// rtl/nexys_starship_pkg.sv - shared state encoding, default constants and saturating helpers
package nexys_starship_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COOL   = 2'd2
    } state_t;

    localparam int DEF_BASE_LIFE   = 32;
    localparam int DEF_COOLDOWN    = 8;
    localparam int DEF_MAX_ESCAPES = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/nexys_starship_spawn_ctrl_if.sv
// rtl/nexys_starship_spawn_ctrl_if.sv - gameplay inputs and monster status outputs of one spawn direction
interface nexys_starship_spawn_ctrl_if;

    logic       play;
    logic       spawn_random;
    logic [3:0] life_hex;
    logic       tick;
    logic       shoot;
    logic       monster_on;
    logic       killed;
    logic       escaped;
    logic [7:0] kills;
    logic [3:0] escapes;
    logic       game_over;

    modport master (
        output play, spawn_random, life_hex, tick, shoot,
        input  monster_on, killed, escaped, kills, escapes, game_over
    );

    modport slave (
        input  play, spawn_random, life_hex, tick, shoot,
        output monster_on, killed, escaped, kills, escapes, game_over
    );

endinterface

// File: rtl/nexys_starship_tick_counter.sv
// rtl/nexys_starship_tick_counter.sv - loadable 8-bit down-counter stepped by the tick strobe
module nexys_starship_tick_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       clear,
    input  logic       dec,
    output logic       zero_next
);

    logic [7:0] count_d;
    logic [7:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted while the next decrement will reach zero.
    assign zero_next = (count_q == 8'd1);

endmodule

// File: rtl/nexys_starship_spawn_ctrl.sv
// rtl/nexys_starship_spawn_ctrl.sv - monster spawn / lifetime / cooldown FSM with kill and escape scoring
module nexys_starship_spawn_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int BASE_LIFE   = DEF_BASE_LIFE,
    parameter int COOLDOWN    = DEF_COOLDOWN,
    parameter int MAX_ESCAPES = DEF_MAX_ESCAPES
) (
    input logic                          Clk,
    input logic                          Reset,
    nexys_starship_spawn_ctrl_if.slave   bus
);

    if ((BASE_LIFE < 0) || (BASE_LIFE + 15 > 255) || (COOLDOWN < 1) || (COOLDOWN > 255) ||
        (MAX_ESCAPES < 1) || (MAX_ESCAPES > 15)) begin : g_bad_params
        $error("nexys_starship_spawn_ctrl: parameter out of range");
    end

    localparam logic [7:0] BASE_LIFE8   = 8'(BASE_LIFE);
    localparam logic [7:0] COOLDOWN8    = 8'(COOLDOWN);
    localparam logic [3:0] MAX_ESCAPES4 = 4'(MAX_ESCAPES);

    state_t     state_d,      state_q;
    logic       monster_on_d, monster_on_q;
    logic       killed_d,     killed_q;
    logic       escaped_d,    escaped_q;
    logic [7:0] kills_d,      kills_q;
    logic [3:0] escapes_d,    escapes_q;
    logic       game_over_d,  game_over_q;

    logic life_load, life_clear, life_dec, life_zero_next;
    logic cool_load, cool_clear, cool_dec, cool_zero_next;

    nexys_starship_tick_counter u_life (
        .clk       (Clk),
        .rst       (Reset),
        .load      (life_load),
        .load_val  (BASE_LIFE8 + {4'd0, bus.life_hex}),
        .clear     (life_clear),
        .dec       (life_dec),
        .zero_next (life_zero_next)
    );

    nexys_starship_tick_counter u_cool (
        .clk       (Clk),
        .rst       (Reset),
        .load      (cool_load),
        .load_val  (COOLDOWN8),
        .clear     (cool_clear),
        .dec       (cool_dec),
        .zero_next (cool_zero_next)
    );

    always_comb begin
        state_d     = state_q;
        killed_d    = 1'b0;
        escaped_d   = 1'b0;
        kills_d     = kills_q;
        escapes_d   = escapes_q;
        game_over_d = game_over_q;
        life_load   = 1'b0;
        life_clear  = 1'b0;
        life_dec    = 1'b0;
        cool_load   = 1'b0;
        cool_clear  = 1'b0;
        cool_dec    = 1'b0;

        // A finished game or a paused player parks the FSM; scores stay put.
        if (game_over_q || !bus.play) begin
            state_d    = ST_IDLE;
            life_clear = 1'b1;
            cool_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.spawn_random) begin
                        state_d   = ST_ACTIVE;
                        life_load = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Shooting wins over an expiring tick on the same cycle.
                    if (bus.shoot) begin
                        state_d    = ST_COOL;
                        killed_d   = 1'b1;
                        kills_d    = sat_inc8(kills_q);
                        life_clear = 1'b1;
                        cool_load  = 1'b1;
                    end else if (bus.tick) begin
                        life_dec = 1'b1;
                        if (life_zero_next) begin
                            state_d   = ST_COOL;
                            escaped_d = 1'b1;
                            escapes_d = sat_inc4(escapes_q);
                            cool_load = 1'b1;
                            if (sat_inc4(escapes_q) >= MAX_ESCAPES4) begin
                                game_over_d = 1'b1;
                            end
                        end
                    end
                end
                ST_COOL: begin
                    if (bus.tick) begin
                        cool_dec = 1'b1;
                        if (cool_zero_next) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    life_clear = 1'b1;
                    cool_clear = 1'b1;
                end
            endcase
        end

        monster_on_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            monster_on_q <= 1'b0;
            killed_q     <= 1'b0;
            escaped_q    <= 1'b0;
            kills_q      <= 8'd0;
            escapes_q    <= 4'd0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            monster_on_q <= monster_on_d;
            killed_q     <= killed_d;
            escaped_q    <= escaped_d;
            kills_q      <= kills_d;
            escapes_q    <= escapes_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.monster_on = monster_on_q;
    assign bus.killed     = killed_q;
    assign bus.escaped    = escaped_q;
    assign bus.kills      = kills_q;
    assign bus.escapes    = escapes_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_nexys_starship_spawn_ctrl.sv
// tb/tb_nexys_starship_spawn_ctrl.sv - directed self-checking bench for the spawn controller
module tb_nexys_starship_spawn_ctrl;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    nexys_starship_spawn_ctrl_if bus ();

    nexys_starship_spawn_ctrl #(
        .BASE_LIFE   (32),
        .COOLDOWN    (8),
        .MAX_ESCAPES (3)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_kills = 0;
    int exp_escapes = 0;

    // {monster_on, killed, escaped, game_over}
    logic [3:0] st;
    assign st = {bus.monster_on, bus.killed, bus.escaped, bus.game_over};

    task automatic tick_once();
        @(negedge Clk) bus.tick = 1'b1;
        @(negedge Clk) bus.tick = 1'b0;
    endtask

    task automatic spawn(input logic [3:0] hex);
        @(negedge Clk) begin bus.spawn_random = 1'b1; bus.life_hex = hex; end
        @(negedge Clk) bus.spawn_random = 1'b0;
    endtask

    task automatic shoot_once();
        @(negedge Clk) bus.shoot = 1'b1;
        @(negedge Clk) bus.shoot = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk) Reset = 1'b0;
        exp_kills = 0;
        exp_escapes = 0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL reset_status got=%b exp=0000", st); end
        checks++; if (bus.kills !== 8'd0) begin errors++; $display("FAIL reset_kills got=%0d exp=0", bus.kills); end
        checks++; if (bus.escapes !== 4'd0) begin errors++; $display("FAIL reset_escapes got=%0d exp=0", bus.escapes); end
        Reset = 1'b0;
    endtask

    task automatic test_spawn_escape();
        bus.play = 1'b1;
        spawn(4'd5);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL esc_spawn got=%b exp=1000", st); end
        repeat (36) tick_once();
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL esc_tick36 got=%b exp=1000", st); end
        tick_once();
        exp_escapes = 1;
        checks++; if (st !== 4'b0010) begin errors++; $display("FAIL esc_pulse got=%b exp=0010", st); end
        checks++; if (bus.escapes !== 4'(exp_escapes)) begin errors++; $display("FAIL esc_count got=%0d exp=%0d", bus.escapes, exp_escapes); end
        @(negedge Clk);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL esc_one_cycle got=%b exp=0000", st); end
        bus.spawn_random = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick_once();
            checks++; if (bus.monster_on !== 1'b0) begin errors++; $display("FAIL esc_cool_%0d got=%b exp=0", i, bus.monster_on); end
        end
        tick_once();
        bus.spawn_random = 1'b0;
        checks++; if (bus.monster_on !== 1'b0) begin errors++; $display("FAIL esc_cool_8 got=%b exp=0", bus.monster_on); end
    endtask

    task automatic test_spawn_kill();
        spawn(4'd0);
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL kill_spawn got=%b exp=1000", st); end
        repeat (10) tick_once();
        shoot_once();
        exp_kills++;
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL kill_pulse got=%b exp=0100", st); end
        checks++; if (bus.kills !== 8'(exp_kills)) begin errors++; $display("FAIL kill_count got=%0d exp=%0d", bus.kills, exp_kills); end
        checks++; if (bus.escapes !== 4'(exp_escapes)) begin errors++; $display("FAIL kill_escapes got=%0d exp=%0d", bus.escapes, exp_escapes); end
        @(negedge Clk);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL kill_one_cycle got=%b exp=0000", st); end
        bus.spawn_random = 1'b1;
        shoot_once();
        checks++; if ({bus.killed, bus.kills} !== {1'b0, 8'(exp_kills)}) begin errors++; $display("FAIL kill_cool_shoot got=%b/%0d exp=0/%0d", bus.killed, bus.kills, exp_kills); end
        for (int i = 1; i <= 7; i++) begin
            tick_once();
            checks++; if (bus.monster_on !== 1'b0) begin errors++; $display("FAIL kill_cool_%0d got=%b exp=0", i, bus.monster_on); end
        end
        tick_once();
        bus.spawn_random = 1'b0;
        checks++; if (bus.monster_on !== 1'b0) begin errors++; $display("FAIL kill_cool_8 got=%b exp=0", bus.monster_on); end
    endtask

    task automatic test_shoot_idle();
        shoot_once();
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL idle_shoot_status got=%b exp=0000", st); end
        checks++; if (bus.kills !== 8'(exp_kills)) begin errors++; $display("FAIL idle_shoot_kills got=%0d exp=%0d", bus.kills, exp_kills); end
    endtask

    task automatic test_simultaneous();
        spawn(4'd0);
        repeat (31) tick_once();
        checks++; if (st !== 4'b1000) begin errors++; $display("FAIL simul_life1 got=%b exp=1000", st); end
        @(negedge Clk) begin bus.tick = 1'b1; bus.shoot = 1'b1; end
        @(negedge Clk) begin bus.tick = 1'b0; bus.shoot = 1'b0; end
        exp_kills++;
        checks++; if (st !== 4'b0100) begin errors++; $display("FAIL simul_pulse got=%b exp=0100", st); end
        checks++; if (bus.kills !== 8'(exp_kills)) begin errors++; $display("FAIL simul_kills got=%0d exp=%0d", bus.kills, exp_kills); end
        checks++; if (bus.escapes !== 4'(exp_escapes)) begin errors++; $display("FAIL simul_escapes got=%0d exp=%0d", bus.escapes, exp_escapes); end
        repeat (8) tick_once();
    endtask

    task automatic test_play_drop();
        spawn(4'd3);
        repeat (5) tick_once();
        @(negedge Clk) bus.play = 1'b0;
        @(negedge Clk);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL drop_status got=%b exp=0000", st); end
        checks++; if ({bus.kills, bus.escapes} !== {8'(exp_kills), 4'(exp_escapes)}) begin errors++; $display("FAIL drop_counts got=%0d/%0d exp=%0d/%0d", bus.kills, bus.escapes, exp_kills, exp_escapes); end
        bus.play = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL drop_stay_idle got=%b exp=0000", st); end
    endtask

    task automatic test_reset_mid_active();
        spawn(4'd0);
        repeat (3) tick_once();
        #2 Reset = 1'b1;
        #1;
        checks++; if (st !== 4'b0000) begin errors++; $display("FAIL async_rst_status got=%b exp=0000", st); end
        checks++; if ({bus.kills, bus.escapes} !== 12'd0) begin errors++; $display("FAIL async_rst_counts got=%0d/%0d exp=0/0", bus.kills, bus.escapes); end
        @(negedge Clk) Reset = 1'b0;
        exp_kills = 0;
        exp_escapes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checks++; if (st !== 4'b0000) begin errors++; $display("FAIL rst_release_%0d got=%b exp=0000", i, st); end
        end
    endtask

    task automatic test_game_over();
        for (int e = 1; e <= 3; e++) begin
            spawn(4'd0);
            repeat (32) tick_once();
            exp_escapes++;
            checks++; if ({bus.escaped, bus.game_over} !== {1'b1, (e == 3)}) begin errors++; $display("FAIL go_escape_%0d got=%b%b exp=1%0d", e, bus.escaped, bus.game_over, (e == 3)); end
            checks++; if (bus.escapes !== 4'(exp_escapes)) begin errors++; $display("FAIL go_escapes_%0d got=%0d exp=%0d", e, bus.escapes, exp_escapes); end
            if (e < 3) repeat (8) tick_once();
        end
        repeat (9) tick_once();
        spawn(4'd0);
        shoot_once();
        checks++; if (st !== 4'b0001) begin errors++; $display("FAIL go_blocked got=%b exp=0001", st); end
        checks++; if ({bus.kills, bus.escapes} !== {8'(exp_kills), 4'(exp_escapes)}) begin errors++; $display("FAIL go_frozen got=%0d/%0d exp=%0d/%0d", bus.kills, bus.escapes, exp_kills, exp_escapes); end
        pulse_reset();
        checks++; if ({st, bus.escapes} !== 8'd0) begin errors++; $display("FAIL go_cleared got=%b/%0d exp=0000/0", st, bus.escapes); end
        spawn(4'd0);
        checks++; if (bus.monster_on !== 1'b1) begin errors++; $display("FAIL go_respawn got=%b exp=1", bus.monster_on); end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 1; i <= 256; i++) begin
            spawn(4'd0);
            shoot_once();
            if (i == 254) begin
                checks++; if (bus.kills !== 8'd254) begin errors++; $display("FAIL sat_254 got=%0d exp=254", bus.kills); end
            end else if (i >= 255) begin
                checks++; if (bus.kills !== 8'd255) begin errors++; $display("FAIL sat_%0d got=%0d exp=255", i, bus.kills); end
            end
            repeat (8) tick_once();
        end
    endtask

    initial begin
        bus.play = 1'b0;
        bus.spawn_random = 1'b0;
        bus.life_hex = 4'd0;
        bus.tick = 1'b0;
        bus.shoot = 1'b0;
        test_reset();
        test_spawn_escape();
        test_spawn_kill();
        test_shoot_idle();
        test_simultaneous();
        test_play_drop();
        test_reset_mid_active();
        test_game_over();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nexys_starship_spawn_ctrl.md
NEXYS_STARSHIP_SPAWN_CTRL -- requirements
Module: nexys_starship_spawn_ctrl

Interface
REQ-001 Parameter BASE_LIFE, default 32: minimum monster lifetime in ticks.
REQ-002 Parameter COOLDOWN, default 8: ticks after a kill or escape before the next spawn is accepted.
REQ-003 Parameter MAX_ESCAPES, default 3: escapes that end the game.
REQ-004 Port Clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: asynchronous, active-high reset.
REQ-006 Port play, input, 1: gameplay enable level.
REQ-007 Port spawn_random, input, 1: spawn request from the PRNG, sampled every cycle.
REQ-008 Port life_hex, input, 4: random lifetime extension from the PRNG, 0..15 ticks.
REQ-009 Port tick, input, 1: single-cycle timebase strobe.
REQ-010 Port shoot, input, 1: single-cycle player-fire pulse for this direction.
REQ-011 Port monster_on, output, 1: monster present.
REQ-012 Port killed, output, 1: one-cycle pulse when a monster is shot.
REQ-013 Port escaped, output, 1: one-cycle pulse when a monster's lifetime expires.
REQ-014 Port kills, output, 8: kill count, saturating at 255.
REQ-015 Port escapes, output, 4: escape count, saturating at 15.
REQ-016 Port game_over, output, 1: sticky end-of-game flag.

Function
REQ-017 The block SHALL be a three-state FSM (IDLE, ACTIVE, COOL) with all outputs registered.
- IDLE: monster_on=0.
- ACTIVE: monster_on=1.
- COOL: monster_on=0.
REQ-018 In IDLE, when play=1, game_over=0 and spawn_random=1 at edge k, the block SHALL enter ACTIVE and load life = BASE_LIFE + life_hex.
- life_hex is sampled at edge k.
- monster_on is high from edge k onward.
REQ-019 In ACTIVE, each tick SHALL decrement life by 1.
- A tick with life==1 and shoot=0 SHALL pulse escaped, increment escapes, load cool = COOLDOWN and enter COOL.
REQ-020 In ACTIVE, shoot=1 SHALL pulse killed, increment kills, load cool = COOLDOWN and enter COOL.
- The pulse is asserted on the edge after shoot is sampled.
- shoot takes priority over a simultaneous expiring tick; no escaped pulse is produced in that case.
REQ-021 In COOL, each tick SHALL decrement cool by 1.
- Leave for IDLE on the tick where cool==1.
- spawn_random and shoot are ignored in COOL.
REQ-022 shoot SHALL be ignored in IDLE and COOL, with no effect on any counter.
REQ-023 killed and escaped SHALL never both be high, and each SHALL last exactly one cycle.
REQ-024 When escapes reaches MAX_ESCAPES, game_over SHALL be set on that same edge and remain set until Reset.
REQ-025 game_over=1 SHALL force IDLE from the next edge onward and block all spawns.
- kills and escapes freeze at their current values.
REQ-026 play=0 SHALL force IDLE on the next edge.
- life and cool are cleared; no killed or escaped pulse is emitted.
- kills, escapes and game_over are retained.
REQ-027 kills and escapes SHALL saturate at their maximum values and never wrap.
REQ-028 The life register SHALL be 8 bits wide.
- BASE_LIFE+15 ≤ 255 and 1 ≤ COOLDOWN ≤ 255 are required parameter constraints.
- Violating them is an elaboration error.

Reset
REQ-029 Reset SHALL asynchronously force the following, independent of Clk:
- state=IDLE.
- monster_on=0, killed=0, escaped=0.
- kills=0, escapes=0, game_over=0.
- life=0, cool=0.
REQ-030 Reset asserted mid-ACTIVE SHALL drop monster_on immediately and emit no pulse on release.

Structure
REQ-031 The state encoding and the default BASE_LIFE, COOLDOWN and MAX_ESCAPES constants SHALL reside in the shared package nexys_starship_pkg.
REQ-032 A single sub-module, nexys_starship_tick_counter, SHALL implement the loadable, tick-decremented 8-bit down-counter with a zero-next flag.
- It is instanced once for life and once for cool.
- Alternatively, one instance is time-shared between them.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Spawn and escape: play=1, spawn_random pulse with life_hex=5, no shoot → monster_on for 37 ticks, then escaped pulse, escapes=1, monster_on=0 for 8 ticks.
- Spawn and kill: spawn with life_hex=0, shoot after 10 ticks → killed pulse 1 cycle later, kills=1, no escaped; spawn_random during the following 8 ticks ignored.
- Simultaneous shoot and expiry: life==1, shoot=1 and tick=1 on the same cycle → killed=1, escaped=0, kills+1, escapes unchanged.
- Game over: three consecutive escapes with MAX_ESCAPES=3 → game_over=1 on the third escape; later spawn_random pulses leave monster_on=0 until Reset.
- play drop: play=0 mid-ACTIVE → monster_on=0 next cycle, no pulses, kills and escapes unchanged.
- Reset mid-ACTIVE: asynchronous Reset → all outputs 0 before the next Clk edge; saturation check with 256 kills forced → kills holds at 255.
